// File: rtl/brisc_pkg.sv
// Shared types and sizing for the memory arbiter and its neighbours.
package brisc_pkg;

  localparam int ADDRESS_WIDTH    = 32;
  localparam int CACHE_LINE_WIDTH = 128;

  // Arbiter FSM states: idle, or serving one of the two caches.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // Requester identity, used for round-robin bookkeeping.
  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_e;

  // Map a winning requester onto the busy state that serves it.
  function automatic arb_state_e busy_state(input requester_e who);
    if (who == ICACHE) begin
      return BUSY_I;
    end else begin
      return BUSY_D;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the arbiter.
// slave is the arbiter's view, master is the caches/memory view.
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH    = brisc_pkg::ADDRESS_WIDTH,
  parameter int CACHE_LINE_WIDTH = brisc_pkg::CACHE_LINE_WIDTH
) ();

  logic                        i_req;
  logic                        d_req;
  logic                        i_grant;
  logic                        d_grant;
  logic [ADDRESS_WIDTH-1:0]    i_addr;
  logic [ADDRESS_WIDTH-1:0]    d_addr;
  logic [CACHE_LINE_WIDTH-1:0] i_data;
  logic [CACHE_LINE_WIDTH-1:0] d_data;
  logic                        i_write;
  logic                        d_write;
  logic                        mem_req_valid;
  logic [ADDRESS_WIDTH-1:0]    mem_req_addr;
  logic [CACHE_LINE_WIDTH-1:0] mem_req_data;
  logic                        mem_req_write;
  logic                        mem_resp;
  logic                        i_resp;
  logic                        d_resp;
  logic                        spurious_resp;

  modport slave (
    input  i_req, d_req, i_addr, d_addr, i_data, d_data, i_write, d_write, mem_resp,
    output i_grant, d_grant, mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
           i_resp, d_resp, spurious_resp
  );

  modport master (
    output i_req, d_req, i_addr, d_addr, i_data, d_data, i_write, d_write, mem_resp,
    input  i_grant, d_grant, mem_req_valid, mem_req_addr, mem_req_data, mem_req_write,
           i_resp, d_resp, spurious_resp
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between icache and dcache.
// One transaction at a time; each ends with exactly one mem_resp pulse.
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = brisc_pkg::ADDRESS_WIDTH,
  parameter int CACHE_LINE_WIDTH = brisc_pkg::CACHE_LINE_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e                  state_q, state_d;
  requester_e                  last_owner_q, last_owner_d;
  requester_e                  winner_s;
  logic                        first_q, first_d;
  logic                        spurious_q, spurious_d;
  logic [ADDRESS_WIDTH-1:0]    i_addr_s, d_addr_s;
  logic [CACHE_LINE_WIDTH-1:0] i_data_s, d_data_s;

  assign i_addr_s = bus.i_addr;
  assign d_addr_s = bus.d_addr;
  assign i_data_s = bus.i_data;
  assign d_data_s = bus.d_data;

  // State register: FSM state, round-robin history, request pulse and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_owner_q <= DCACHE;
      first_q      <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      first_q      <= first_d;
      spurious_q   <= spurious_d;
    end
  end

  // Next-state logic: arbitrate from IDLE, hold the grant until memory completes.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    first_d      = 1'b0;
    spurious_d   = spurious_q;
    winner_s     = ICACHE;
    case (state_q)
      IDLE: begin
        // A completion with nothing outstanding is an error, not a transaction end.
        if (bus.mem_resp) begin
          spurious_d = 1'b1;
        end else begin
          spurious_d = spurious_q;
        end
        if (bus.i_req && bus.d_req) begin
          if (last_owner_q == ICACHE) begin
            winner_s = DCACHE;
          end else begin
            winner_s = ICACHE;
          end
        end else if (bus.d_req) begin
          winner_s = DCACHE;
        end else begin
          winner_s = ICACHE;
        end
        if (bus.i_req || bus.d_req) begin
          state_d      = busy_state(winner_s);
          last_owner_d = winner_s;
          first_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        // Requester dropping req does not abort; only mem_resp ends the transaction.
        if (bus.mem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: grants and forwarded request from state, completion routed to owner.
  always_comb begin
    bus.i_grant       = 1'b0;
    bus.d_grant       = 1'b0;
    bus.mem_req_addr  = {ADDRESS_WIDTH{1'b0}};
    bus.mem_req_data  = {CACHE_LINE_WIDTH{1'b0}};
    bus.mem_req_write = 1'b0;
    bus.i_resp        = 1'b0;
    bus.d_resp        = 1'b0;
    bus.mem_req_valid = first_q;
    bus.spurious_resp = spurious_q;
    case (state_q)
      BUSY_I: begin
        bus.i_grant       = 1'b1;
        bus.mem_req_addr  = i_addr_s;
        bus.mem_req_data  = i_data_s;
        bus.mem_req_write = bus.i_write;
        bus.i_resp        = bus.mem_resp;
      end
      BUSY_D: begin
        bus.d_grant       = 1'b1;
        bus.mem_req_addr  = d_addr_s;
        bus.mem_req_data  = d_data_s;
        bus.mem_req_write = bus.d_write;
        bus.d_resp        = bus.mem_resp;
      end
      default: begin
        bus.i_grant = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;
  import brisc_pkg::*;

  localparam int AW = ADDRESS_WIDTH;
  localparam int CW = CACHE_LINE_WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: owner 0 = none, 1 = icache, 2 = dcache.
  int   m_owner;
  int   m_last;
  bit   m_first;
  bit   m_spur;

  // Memory responder controls.
  bit   auto_resp;
  int   lat_cfg;
  int   cnt;

  mem_arbiter_if #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(CW)) bus ();

  mem_arbiter #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_first = 1'b0;
    m_spur  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    if (m_owner == 0) begin
      if (bus.mem_resp) m_spur = 1'b1;
      if (bus.i_req && bus.d_req) m_owner = (m_last == 1) ? 2 : 1;
      else if (bus.i_req)         m_owner = 1;
      else if (bus.d_req)         m_owner = 2;
      else                        m_owner = 0;
      m_first = (m_owner != 0);
      if (m_owner != 0) m_last = m_owner;
    end else begin
      m_first = 1'b0;
      if (bus.mem_resp) m_owner = 0;
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] e_addr;
    logic [CW-1:0] e_data;
    logic          e_wr;
    e_addr = '0;
    e_data = '0;
    e_wr   = 1'b0;
    if (m_owner == 1) begin
      e_addr = bus.i_addr; e_data = bus.i_data; e_wr = bus.i_write;
    end else if (m_owner == 2) begin
      e_addr = bus.d_addr; e_data = bus.d_data; e_wr = bus.d_write;
    end
    chk("i_grant",       bus.i_grant,       (m_owner == 1));
    chk("d_grant",       bus.d_grant,       (m_owner == 2));
    chk("mem_req_valid", bus.mem_req_valid, m_first);
    chk("mem_req_addr",  bus.mem_req_addr,  e_addr);
    chk("mem_req_data",  bus.mem_req_data,  e_data);
    chk("mem_req_write", bus.mem_req_write, e_wr);
    chk("i_resp",        bus.i_resp,        (m_owner == 1) && bus.mem_resp);
    chk("d_resp",        bus.d_resp,        (m_owner == 2) && bus.mem_resp);
    chk("spurious_resp", bus.spurious_resp, m_spur);
  endtask

  // One clock: drive memory response, check mid-cycle, then advance the model.
  task automatic cycle();
    if (auto_resp) begin
      if (m_owner != 0) begin
        if (m_first) cnt = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        bus.mem_resp = (cnt == 0);
        cnt--;
      end else begin
        bus.mem_resp = 1'b0;
      end
    end
    #1;
    check_all();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_update();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset();
    bus.mem_resp = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    bus.i_addr = '0;  bus.d_addr = '0;
    bus.i_data = '0;  bus.d_data = '0;
    bus.i_write = 1'b0; bus.d_write = 1'b0;
    bus.mem_resp = 1'b0;
    auto_resp = 1'b0; lat_cfg = 1; cnt = 0;
    model_reset();

    // Reset state.
    #2;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Single icache read at 0x100, completion five cycles after grant.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
    cycle();
    chk("icache_grant_latency", bus.i_grant, 1'b1);
    repeat (5) cycle();
    bus.mem_resp = 1'b1; bus.i_req = 1'b0;
    cycle();
    bus.mem_resp = 1'b0;
    cycle();

    // Both requesting from reset: icache, dcache, icache.
    apply_reset();
    auto_resp = 1'b1; lat_cfg = 2;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    bus.i_addr = 32'h0000_1000; bus.d_addr = 32'h0000_2000;
    repeat (13) cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    for (int k = 0; k < 10 && m_owner != 0; k++) cycle();
    cycle();

    // dcache write-back of a patterned line.
    bus.d_req = 1'b1; bus.d_write = 1'b1;
    bus.d_addr = 32'h0000_0200; bus.d_data = {16{8'hA5}};
    cycle();
    bus.d_req = 1'b0;
    repeat (4) cycle();
    bus.d_write = 1'b0;

    // Owner drops its request mid-transaction; dcache is served afterwards.
    lat_cfg = 3;
    bus.i_req = 1'b1;
    cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b1;
    repeat (9) cycle();
    bus.d_req = 1'b0;
    repeat (5) cycle();

    // Zero-latency completion coincident with the request pulse.
    lat_cfg = 0;
    bus.i_req = 1'b1;
    cycle();
    bus.i_req = 1'b0;
    repeat (3) cycle();

    // Completion pulse with nothing outstanding.
    auto_resp = 1'b0;
    bus.mem_resp = 1'b1;
    cycle();
    bus.mem_resp = 1'b0;
    repeat (3) cycle();
    chk("spurious_sticky", bus.spurious_resp, 1'b1);

    // Random traffic with random memory latency.
    auto_resp = 1'b1; lat_cfg = -1;
    for (int n = 0; n < 400; n++) begin
      bus.i_req   = 1'($urandom_range(0, 1));
      bus.d_req   = 1'($urandom_range(0, 1));
      bus.i_addr  = $urandom;
      bus.d_addr  = $urandom;
      bus.i_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.d_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.i_write = 1'($urandom_range(0, 1));
      bus.d_write = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    for (int k = 0; k < 10 && m_owner != 0; k++) cycle();
    cycle();

    // Reset in the middle of a dcache transaction, then a tie goes to icache.
    lat_cfg = 20;
    bus.d_req = 1'b1;
    repeat (3) cycle();
    chk("busy_d_before_reset", bus.d_grant, 1'b1);
    apply_reset();
    chk("spurious_cleared", bus.spurious_resp, 1'b0);
    lat_cfg = 1;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    cycle();
    chk("tie_after_reset", bus.i_grant, 1'b1);
    repeat (6) cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDRESS_WIDTH, default brisc_pkg::ADDRESS_WIDTH, memory address width.
REQ-002 Parameter: CACHE_LINE_WIDTH, default brisc_pkg::CACHE_LINE_WIDTH, line data width.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 i_req / d_req  in  1  icache / dcache request (cache_top arbiter_req).
REQ-006 i_grant / d_grant  out  1  grant to icache / dcache (cache_top arbiter_grant).
REQ-007 i_addr, d_addr  in  ADDRESS_WIDTH  requester line address.
REQ-008 i_data, d_data  in  CACHE_LINE_WIDTH  requester write line.
REQ-009 i_write, d_write  in  1  requester write (eviction) flag.
REQ-010 mem_req_valid  out  1  one-cycle request pulse to memory.
REQ-011 mem_req_addr / mem_req_data / mem_req_write  out  ADDRESS_WIDTH / CACHE_LINE_WIDTH / 1  forwarded owner request.
REQ-012 mem_resp  in  1  memory completion pulse.
REQ-013 i_resp / d_resp  out  1  completion routed to owner.
REQ-014 spurious_resp  out  1  sticky error flag.

Function
REQ-015 FSM states IDLE, BUSY_I, BUSY_D (arb_state_e).
REQ-016 IDLE, only i_req -> BUSY_I next edge; only d_req -> BUSY_D.
REQ-017 IDLE, both requesting -> grant the requester not equal to last_owner (round-robin); last_owner updates on each grant.
REQ-018 i_grant = (state==BUSY_I), d_grant = (state==BUSY_D); both registered, never simultaneously 1.
REQ-019 mem_req_valid is 1 exactly in the first cycle of each BUSY state (one pulse per transaction).
REQ-020 mem_req_addr/data/write equal owner's inputs while BUSY_x; all zero in IDLE.
REQ-021 In BUSY_x, mem_resp=1 -> x_resp=1 combinationally same cycle; next edge -> IDLE.
REQ-022 Grant holds until mem_resp regardless of owner's req dropping mid-transaction; transaction completes, x_resp still pulses.
REQ-023 Minimum one IDLE cycle between transactions; back-to-back service latency is req-to-grant 1 cycle from IDLE.
REQ-024 mem_resp in IDLE: no resp routed, state unchanged, spurious_resp set and held until reset.
REQ-025 mem_resp coincident with mem_req_valid (first BUSY cycle) is a valid zero-latency completion.
REQ-026 Every transaction, read or write, completes by exactly one mem_resp.

Reset
REQ-027 reset=0 asynchronously forces state=IDLE, last_owner=DCACHE (first tie goes to icache), spurious_resp=0.
REQ-028 During reset all outputs 0; reset mid-transaction aborts it with no x_resp pulse.
REQ-029 First arbitration occurs on the first posedge after reset deasserts.

Structure
REQ-030 arb_state_e and requester_e (ICACHE, DCACHE) defined in brisc_pkg.
REQ-031 Single flat module; no sub-modules.
REQ-032 Instantiated at top level between fetch-stage icache and memory-stage dcache cache_top ports and main memory.

Verification
REQ-033 i_req=1 only, addr 0x100, mem_resp 5 cycles after grant -> i_grant 1 cycle after req, one mem_req_valid with addr 0x100, i_resp pulse, IDLE next.
REQ-034 i_req and d_req high together from reset -> icache first, dcache second, then icache; grants never overlap, one IDLE gap each.
REQ-035 d_req write, d_data 0xA5.., addr 0x200 -> mem_req_write=1, data forwarded, d_resp on mem_resp.
REQ-036 Owner drops req mid-transaction -> grant held, completion still routed, other requester served after.
REQ-037 mem_resp pulse in IDLE -> no x_resp, spurious_resp=1 sticky until reset.
REQ-038 reset asserted in BUSY_D -> all outputs 0 immediately; after release, tie grants icache.
